// File: rtl/sha256_round_ctrl_if.sv
// sha256_round_ctrl_if
// Block-in / digest-out bundle for sha256_round_ctrl.
//   in_valid  : upstream has a block on in_block
//   in_ready  : controller can accept a block (IDLE only)
//   in_block  : 512-bit block, W0 in [511:480] .. W15 in [31:0]
//   in_first  : 1 = start from IV (only with SHA256_MULTIBLOCK_EN)
//   out_valid : one-cycle completion pulse
//   out_hash  : {H0..H7}, H0 in [255:224], held between completions
// Modports: master = block feeder / digest consumer, slave = controller.
// Optional feature macro: SHA256_MULTIBLOCK_EN (adds in_first).
interface sha256_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
`ifdef SHA256_MULTIBLOCK_EN
  logic         in_first;
`endif
  logic         out_valid;
  logic [255:0] out_hash;

`ifdef SHA256_MULTIBLOCK_EN
  modport master (output in_valid, in_block, in_first,
                  input  in_ready, out_valid, out_hash);
  modport slave  (input  in_valid, in_block, in_first,
                  output in_ready, out_valid, out_hash);
`else
  modport master (output in_valid, in_block,
                  input  in_ready, out_valid, out_hash);
  modport slave  (input  in_valid, in_block,
                  output in_ready, out_valid, out_hash);
`endif
endinterface

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
// Runs the 64-round SHA-256 compression of one 512-bit block and
// produces the 256-bit chaining value.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : sha256_round_ctrl_if.slave (block in, digest out)
// Optional feature macro: SHA256_MULTIBLOCK_EN -- when defined, in_first
// selects IV (1) or the previous chaining value (0) at acceptance;
// otherwise H is reloaded with IV for every block.
// Also contains func_t2: T2 = Sigma0(a) + Maj(a,b,c).

module func_t2 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] t2_o
);
  logic [31:0] sig0, maj;
  assign sig0 = {a_i[1:0], a_i[31:2]} ^ {a_i[12:0], a_i[31:13]} ^ {a_i[21:0], a_i[31:22]};
  assign maj  = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
  assign t2_o = sig0 + maj;
endmodule

module sha256_round_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  sha256_round_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t       state_q, state_d;
  logic [5:0]   round_q;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]  w_q  [16];
  logic [31:0]  hv_q [8];
  logic [255:0] hash_q;

  logic         accept;
  logic [31:0]  s1e, ch, t1, t2, s0w, s1w, w_new;
  logic [31:0]  init_h [8];
  logic [31:0]  wv     [8];
  logic [31:0]  sum    [8];

  assign accept        = bus.in_valid && (state_q == IDLE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_hash  = hash_q;

  func_t2 u_t2 (.a_i(a_q), .b_i(b_q), .c_i(c_q), .t2_o(t2));

  assign s1e = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
  assign ch  = (e_q & f_q) ^ (~e_q & g_q);
  assign t1  = h_q + s1e + ch + K[round_q] + w_q[0];

  // Window holds W[t]..W[t+15]; the appended word is W[t+16].
  assign s0w   = rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3);
  assign s1w   = rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10);
  assign w_new = s1w + w_q[9] + s0w + w_q[0];

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
`ifdef SHA256_MULTIBLOCK_EN
      init_h[i] = bus.in_first ? IV[i] : hv_q[i];
`else
      init_h[i] = IV[i];
`endif
    end
    wv = '{a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
    for (int unsigned i = 0; i < 8; i++) sum[i] = hv_q[i] + wv[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (round_q == 6'd63) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_q <= '0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) hv_q[i] <= IV[i];
      hash_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          for (int unsigned i = 0; i < 16; i++) w_q[i] <= bus.in_block[32*(15-i) +: 32];
          for (int unsigned i = 0; i < 8; i++) hv_q[i] <= init_h[i];
          {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <=
            {init_h[0], init_h[1], init_h[2], init_h[3],
             init_h[4], init_h[5], init_h[6], init_h[7]};
          round_q <= '0;
        end
        ROUND: begin
          for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new;
          h_q <= g_q;
          g_q <= f_q;
          f_q <= e_q;
          e_q <= d_q + t1;
          d_q <= c_q;
          c_q <= b_q;
          b_q <= a_q;
          a_q <= t1 + t2;
          round_q <= round_q + 6'd1;
        end
        FINAL: begin
          for (int unsigned i = 0; i < 8; i++) hv_q[i] <= sum[i];
          hash_q <= {sum[0], sum[1], sum[2], sum[3], sum[4], sum[5], sum[6], sum[7]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
// Directed vectors with known SHA-256 digests for sha256_round_ctrl.
// Optional feature macro: SHA256_MULTIBLOCK_EN (enables the two-block test).
module tb_sha256_round_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sha256_round_ctrl_if bus ();
  sha256_round_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
`ifdef SHA256_MULTIBLOCK_EN
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_M  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`endif

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Presents blk at a negedge while in_ready is high, then counts cycles
  // until out_valid (lat = 66 expected). in_block is scrambled after
  // acceptance; with hold=1 in_valid stays high throughout.
  task automatic send(input logic [511:0] blk, input logic first, input logic hold,
                      output int lat, output int busy_ready);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {255'h0, bus.in_ready}, 256'h1);
    bus.in_block = blk;
`ifdef SHA256_MULTIBLOCK_EN
    bus.in_first = first;
`endif
    bus.in_valid = 1'b1;
    lat = 0;
    busy_ready = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) bus.in_valid = 1'b0;
      bus.in_block = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (bus.in_ready) busy_ready++;
    end while (!bus.out_valid && lat < 200);
  endtask

  initial begin
    int lat, busy, pulses;
    logic [255:0] h1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_block = '0;
`ifdef SHA256_MULTIBLOCK_EN
    bus.in_first = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {255'h0, bus.in_ready},  256'h1);
    check("rst_out_valid", {255'h0, bus.out_valid}, 256'h0);
    check("rst_out_hash",  bus.out_hash, 256'h0);

    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("idle_no_pulse", 256'(pulses), 256'h0);

    // "abc"
    send(BLK_ABC, 1'b1, 1'b0, lat, busy);
    check("abc_latency", 256'(lat), 256'd66);
    check("abc_busy_ready", 256'(busy), 256'h0);
    check("abc_hash", bus.out_hash, DIG_ABC);
    repeat (5) @(negedge clk);
    check("abc_hash_held", bus.out_hash, DIG_ABC);

    // empty message, in_valid held high through the busy period
    send(BLK_EMPTY, 1'b1, 1'b1, lat, busy);
    check("empty_latency", 256'(lat), 256'd66);
    check("empty_busy_ready", 256'(busy), 256'h0);
    check("empty_hash", bus.out_hash, DIG_EMPTY);
    @(negedge clk);
    check("empty_ready_back", {255'h0, bus.in_ready}, 256'h1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("empty_no_reaccept", {255'h0, bus.in_ready}, 256'h1);

`ifdef SHA256_MULTIBLOCK_EN
    send(BLK_M1, 1'b1, 1'b0, lat, busy);
    h1 = bus.out_hash;
    send(BLK_M2, 1'b0, 1'b0, lat, busy);
    check("multi_latency", 256'(lat), 256'd66);
    check("multi_hash", bus.out_hash, DIG_M);
    check("multi_chained", {255'h0, (h1 !== DIG_M)}, 256'h1);
`endif

    // reset during round 30 of "abc"
    bus.in_block = BLK_ABC;
`ifdef SHA256_MULTIBLOCK_EN
    bus.in_first = 1'b0;
`endif
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", {255'h0, bus.in_ready}, 256'h1);
    check("midrst_out_hash", bus.out_hash, 256'h0);
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("midrst_no_pulse", 256'(pulses), 256'h0);
    send(BLK_ABC, 1'b1, 1'b0, lat, busy);
    check("midrst_abc_latency", 256'(lat), 256'd66);
    check("midrst_abc_hash", bus.out_hash, DIG_ABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
